// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : types_pkg
//  Description : Shared type definitions. state_t is the global acquisition
//                state broadcast to the channel logic.
//  Revision    : 1.0  initial release
// ============================================================================
package types_pkg;

  typedef enum logic [2:0] {
    STATE_STOPPED = 3'd0,
    STATE_INIT    = 3'd1,
    STATE_IDLE    = 3'd2,
    STATE_RUNNING = 3'd3,
    STATE_READOUT = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ch_trigger_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : ch_trigger_gen_multi
//  Description : Multi-channel trigger generator. Synchronises NUM_CH
//                discriminator inputs, applies per-channel polarity/enable,
//                blanks for HOLDOFF_CYCLES after INST_START, combines the
//                channels (OR / AND / MAJORITY / INDEPENDENT), gates on the
//                global state and counts accepted trigger_any rising edges.
//  Build option: define TRIG_DEADTIME_EN to add a per-channel retrigger mask
//                of DEADTIME cycles after each trigger[i] rising edge.
//  Revision    : 1.0  initial release
//
//  Ports
//    FCLK                    sampling clock, all logic on posedge
//    INST_START              synchronous active-high reset, restarts blanking
//    DISCRIMINATOR_OUTPUT    [NUM_CH] raw asynchronous discriminator outputs
//    DISCRIMINATOR_POLARITY  [NUM_CH] 1 = channel is active-low
//    CH_ENABLE               [NUM_CH] per-channel enable
//    TRIG_MODE               [2] 00 OR, 01 AND, 10 MAJORITY, 11 INDEPENDENT
//    MAJ_THRESH              [$clog2(NUM_CH+1)] majority threshold
//    HOLDOFF_CYCLES          [HOLDOFF_W] blanking length after INST_START
//    current_state           global acquisition state (types_pkg::state_t)
//    trigger                 [NUM_CH] registered per-channel trigger
//    trigger_any             registered OR of trigger
//    armed                   1 once blanking has completed
//    trig_count              [CNT_W] saturating count of trigger_any rises
// ============================================================================
module ch_trigger_gen_multi
  import types_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_W   = 8,
  parameter int CNT_W       = 16,
  parameter int DEADTIME    = 4
) (
  input  logic                         FCLK,
  input  logic                         INST_START,
  input  logic [NUM_CH-1:0]            DISCRIMINATOR_OUTPUT,
  input  logic [NUM_CH-1:0]            DISCRIMINATOR_POLARITY,
  input  logic [NUM_CH-1:0]            CH_ENABLE,
  input  logic [1:0]                   TRIG_MODE,
  input  logic [$clog2(NUM_CH+1)-1:0]  MAJ_THRESH,
  input  logic [HOLDOFF_W-1:0]         HOLDOFF_CYCLES,
  input  state_t                       current_state,
  output logic [NUM_CH-1:0]            trigger,
  output logic                         trigger_any,
  output logic                         armed,
  output logic [CNT_W-1:0]             trig_count
);

  localparam int PC_W = $clog2(NUM_CH+1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_MAJ = 2'b10;

  logic [NUM_CH-1:0]    r_sync [SYNC_STAGES];
  logic [0:0]           r_state;
  logic [HOLDOFF_W-1:0] r_blank_cnt;
  logic                 r_armed;
  logic [NUM_CH-1:0]    r_trigger;
  logic                 r_trig_any;
  logic [CNT_W-1:0]     r_count;

  logic [NUM_CH-1:0]    w_hit;
  logic [PC_W-1:0]      w_popcnt;
  logic                 w_gate;
  logic [NUM_CH-1:0]    w_fire_raw;
  logic [NUM_CH-1:0]    w_dt_mask;
  logic [NUM_CH-1:0]    w_trig_next;
  logic                 w_any_next;

  // --------------------------------------------------------------------------
  // Input synchroniser chain
  // --------------------------------------------------------------------------
  always_ff @(posedge FCLK) begin
    if (INST_START) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= DISCRIMINATOR_OUTPUT;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // --------------------------------------------------------------------------
  // Arm FSM: count blanking cycles, then stay armed until the next INST_START
  // --------------------------------------------------------------------------
  always_ff @(posedge FCLK) begin
    if (INST_START) begin
      r_state     <= ST_BLANK;
      r_blank_cnt <= '0;
      r_armed     <= 1'b0;
    end else begin
      case (r_state)
        ST_BLANK: begin
          // HOLDOFF_CYCLES is compared live, so it may be changed while blanking
          if (r_blank_cnt == HOLDOFF_CYCLES) begin
            r_state <= ST_ARMED;
            r_armed <= 1'b1;
          end else begin
            r_blank_cnt <= r_blank_cnt + 1'b1;
          end
        end
        ST_ARMED: begin
          r_state <= ST_ARMED;
          r_armed <= 1'b1;
        end
        default: begin
          r_state <= ST_BLANK;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Hit qualification, state gate and combine rule
  // --------------------------------------------------------------------------
  always_comb begin
    w_hit    = (r_sync[SYNC_STAGES-1] ^ DISCRIMINATOR_POLARITY) & CH_ENABLE;
    w_popcnt = '0;
    for (int i = 0; i < NUM_CH; i++) w_popcnt = w_popcnt + PC_W'(w_hit[i]);
  end

  assign w_gate = !(current_state inside {STATE_STOPPED, STATE_INIT, STATE_READOUT});

  always_comb begin
    w_fire_raw = '0;
    case (TRIG_MODE)
      MODE_OR:  w_fire_raw = w_hit;
      MODE_AND: w_fire_raw = ((w_hit == CH_ENABLE) && (CH_ENABLE != '0)) ? w_hit : '0;
      MODE_MAJ: w_fire_raw = ((w_popcnt >= MAJ_THRESH) && (MAJ_THRESH != '0)) ? w_hit : '0;
      default:  w_fire_raw = w_hit;
    endcase
  end

  assign w_trig_next = w_fire_raw & ~w_dt_mask & {NUM_CH{w_gate & r_armed}};
  assign w_any_next  = |w_trig_next;

`ifdef TRIG_DEADTIME_EN
  // --------------------------------------------------------------------------
  // Retrigger mask: load DEADTIME on each trigger[i] rise, block fire[i]
  // while nonzero. A masked channel cannot rise, so load and decrement
  // never collide.
  // --------------------------------------------------------------------------
  localparam int DT_W = (DEADTIME > 0) ? $clog2(DEADTIME+1) : 1;

  logic [DT_W-1:0] r_dt_cnt [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) w_dt_mask[i] = (r_dt_cnt[i] != '0);
  end

  always_ff @(posedge FCLK) begin
    if (INST_START) begin
      for (int i = 0; i < NUM_CH; i++) r_dt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_trig_next[i] && !r_trigger[i])
          r_dt_cnt[i] <= DT_W'(DEADTIME);
        else if (r_dt_cnt[i] != '0)
          r_dt_cnt[i] <= r_dt_cnt[i] - 1'b1;
      end
    end
  end
`else
  assign w_dt_mask = '0;
`endif

  // --------------------------------------------------------------------------
  // Output registers and saturating trigger counter
  // --------------------------------------------------------------------------
  always_ff @(posedge FCLK) begin
    if (INST_START) begin
      r_trigger  <= '0;
      r_trig_any <= 1'b0;
      r_count    <= '0;
    end else begin
      r_trigger  <= w_trig_next;
      r_trig_any <= w_any_next;
      // Count on the same edge that trigger_any rises
      if (w_any_next && !r_trig_any && (r_count != {CNT_W{1'b1}}))
        r_count <= r_count + 1'b1;
    end
  end

  assign trigger     = r_trigger;
  assign trigger_any = r_trig_any;
  assign armed       = r_armed;
  assign trig_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ch_trigger_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ch_trigger_gen_multi
//  Description : Self-checking bench for ch_trigger_gen_multi. Table-driven
//                combine/gate vectors plus hand-written blanking, latency,
//                gate-drop, counter saturation and deadtime sequences.
//                Honours TRIG_DEADTIME_EN for the deadtime expectation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ch_trigger_gen_multi;
  import types_pkg::*;

  localparam int NUM_CH      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HOLDOFF_W   = 8;
  localparam int CNT_W       = 4;
  localparam int DEADTIME    = 4;

  logic                 FCLK = 1'b0;
  logic                 INST_START;
  logic [NUM_CH-1:0]    disc, pol, en;
  logic [1:0]           mode;
  logic [3:0]           thr;
  logic [HOLDOFF_W-1:0] holdoff;
  state_t               st;
  logic [NUM_CH-1:0]    trigger;
  logic                 trigger_any;
  logic                 armed;
  logic [CNT_W-1:0]     trig_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 FCLK = ~FCLK;

  ch_trigger_gen_multi #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .HOLDOFF_W(HOLDOFF_W),
    .CNT_W(CNT_W), .DEADTIME(DEADTIME)
  ) dut (
    .FCLK(FCLK),
    .INST_START(INST_START),
    .DISCRIMINATOR_OUTPUT(disc),
    .DISCRIMINATOR_POLARITY(pol),
    .CH_ENABLE(en),
    .TRIG_MODE(mode),
    .MAJ_THRESH(thr),
    .HOLDOFF_CYCLES(holdoff),
    .current_state(st),
    .trigger(trigger),
    .trigger_any(trigger_any),
    .armed(armed),
    .trig_count(trig_count)
  );

  typedef struct {
    logic [1:0] mode;
    logic [3:0] thr;
    logic [7:0] en;
    logic [7:0] pol;
    logic [7:0] disc;
    state_t     st;
    logic [7:0] exp_trig;
    logic       exp_any;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge FCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive every channel inactive long enough for triggers and any
  // retrigger mask to drain.
  task automatic idle();
    disc = pol;
    repeat (6) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int highs;
    int first;
    logic [CNT_W-1:0] cnt_before;

    //            mode   thr   en     pol    disc   state          exp    any
    vecs[0]  = '{2'b00, 4'd0, 8'hFF, 8'h01, 8'h03, STATE_RUNNING, 8'h02, 1'b1};
    vecs[1]  = '{2'b10, 4'd3, 8'hFF, 8'h00, 8'h03, STATE_RUNNING, 8'h00, 1'b0};
    vecs[2]  = '{2'b10, 4'd3, 8'hFF, 8'h00, 8'h07, STATE_RUNNING, 8'h07, 1'b1};
    vecs[3]  = '{2'b10, 4'd0, 8'hFF, 8'h00, 8'hFF, STATE_RUNNING, 8'h00, 1'b0};
    vecs[4]  = '{2'b10, 4'd3, 8'hFF, 8'h00, 8'h0F, STATE_RUNNING, 8'h0F, 1'b1};
    vecs[5]  = '{2'b01, 4'd0, 8'h0F, 8'h00, 8'hFF, STATE_RUNNING, 8'h0F, 1'b1};
    vecs[6]  = '{2'b01, 4'd0, 8'h0F, 8'h00, 8'h07, STATE_RUNNING, 8'h00, 1'b0};
    vecs[7]  = '{2'b01, 4'd0, 8'h00, 8'h00, 8'hFF, STATE_RUNNING, 8'h00, 1'b0};
    vecs[8]  = '{2'b11, 4'd0, 8'hFF, 8'h00, 8'h05, STATE_RUNNING, 8'h05, 1'b1};
    vecs[9]  = '{2'b00, 4'd0, 8'hF0, 8'h00, 8'h0F, STATE_RUNNING, 8'h00, 1'b0};
    vecs[10] = '{2'b00, 4'd0, 8'hFF, 8'h00, 8'h81, STATE_READOUT, 8'h00, 1'b0};
    vecs[11] = '{2'b00, 4'd0, 8'hFF, 8'h00, 8'h81, STATE_STOPPED, 8'h00, 1'b0};
    vecs[12] = '{2'b00, 4'd0, 8'hFF, 8'h00, 8'h81, STATE_INIT,    8'h00, 1'b0};
    vecs[13] = '{2'b11, 4'd0, 8'hFF, 8'h00, 8'h3C, STATE_IDLE,    8'h3C, 1'b1};

    // ---------------- reset + blanking (HOLDOFF=10, OR, ch0 active) ---------
    INST_START = 1'b1;
    holdoff = 8'd10;
    mode = 2'b00; thr = 4'd0; en = 8'hFF; pol = 8'h00; disc = 8'h01;
    st = STATE_RUNNING;
    repeat (3) tick();
    chk("reset_trigger", 32'(trigger), 32'h0);
    chk("reset_any", 32'(trigger_any), 32'h0);
    chk("reset_armed", 32'(armed), 32'h0);
    chk("reset_count", 32'(trig_count), 32'h0);

    INST_START = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("blank_armed_%0d", k), 32'(armed), 32'h0);
      chk($sformatf("blank_trig_%0d", k), 32'(trigger), 32'h0);
    end
    tick();
    chk("blank_end_armed", 32'(armed), 32'h1);
    chk("blank_end_trig", 32'(trigger), 32'h0);
    tick();
    chk("first_trig", 32'(trigger), 32'h01);
    chk("first_any", 32'(trigger_any), 32'h1);
    chk("first_count", 32'(trig_count), 32'h1);

    // ---------------- polarity + latency ------------------------------------
    pol = 8'h01;
    idle();
    disc = 8'h00;            // ch0 active-low driven low
    tick();
    chk("lat_t1", 32'(trigger), 32'h0);
    tick();
    chk("lat_t2", 32'(trigger), 32'h0);
    tick();
    chk("lat_t3", 32'(trigger), 32'h01);

    // ---------------- table vectors -----------------------------------------
    for (int v = 0; v < NV; v++) begin
      mode = vecs[v].mode; thr = vecs[v].thr; en = vecs[v].en;
      pol = vecs[v].pol; st = vecs[v].st;
      idle();
      disc = vecs[v].disc;
      repeat (SYNC_STAGES + 1) tick();
      chk($sformatf("vec%0d_trig", v), 32'(trigger), 32'(vecs[v].exp_trig));
      chk($sformatf("vec%0d_any", v), 32'(trigger_any), 32'(vecs[v].exp_any));
      chk($sformatf("vec%0d_armed", v), 32'(armed), 32'h1);
    end

    // ---------------- gate drop mid-trigger ---------------------------------
    mode = 2'b01; en = 8'h0F; pol = 8'h00; st = STATE_RUNNING;
    idle();
    disc = 8'hFF;
    repeat (3) tick();
    chk("gate_pre_trig", 32'(trigger), 32'h0F);
    cnt_before = trig_count;
    st = STATE_READOUT;
    tick();
    chk("gate_drop_trig", 32'(trigger), 32'h0);
    chk("gate_drop_any", 32'(trigger_any), 32'h0);
    chk("gate_drop_armed", 32'(armed), 32'h1);
    chk("gate_drop_count", 32'(trig_count), 32'(cnt_before));
    st = STATE_RUNNING;

    // ---------------- counter saturation (HOLDOFF=0) ------------------------
    mode = 2'b11; en = 8'h01; pol = 8'h00; disc = 8'h00;
    holdoff = 8'd0;
    INST_START = 1'b1;
    tick();
    chk("sat_reset_count", 32'(trig_count), 32'h0);
    INST_START = 1'b0;
    tick();
    chk("holdoff0_armed", 32'(armed), 32'h1);
    for (int p = 0; p < 20; p++) begin
      disc = 8'h01;
      tick();
      disc = 8'h00;
      repeat (6) tick();
      if (p == 4) chk("sat_count_5", 32'(trig_count), 32'h5);
    end
    chk("sat_count_15", 32'(trig_count), 32'hF);
    INST_START = 1'b1;
    tick();
    chk("sat_clear", 32'(trig_count), 32'h0);
    INST_START = 1'b0;
    tick();

    // ---------------- deadtime / level following on ch2 ---------------------
    mode = 2'b11; en = 8'hFF; pol = 8'h00; st = STATE_RUNNING;
    idle();
    disc = 8'h04;
    highs = 0;
    first = -1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (trigger[2]) begin
        highs++;
        if (first < 0) first = k;
      end
    end
    chk("dt_first_rise", 32'(first), 32'd3);
`ifdef TRIG_DEADTIME_EN
    chk("dt_high_cycles", 32'(highs), 32'd4);
`else
    chk("dt_high_cycles", 32'(highs), 32'd20);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ch_trigger_gen_multi.md
Name: ch_trigger_gen_multi

Overview:
Parametrised, fully synchronous successor to the per-channel trigger generator. Covers NUM_CH discriminator channels and provides:
- Per-channel polarity and enable
- Programmable post-start blanking window
- Selectable combine mode: OR / AND / majority / independent
- Saturating accepted-trigger counter

Sits between the discriminator front-end and the channel sampling control. It is gated by the global state_t from types_pkg.

Parameters:
NUM_CH, 8, number of discriminator channels (1..32)
SYNC_STAGES, 2, synchroniser flops per discriminator input (>=2)
HOLDOFF_W, 8, width of HOLDOFF_CYCLES input
CNT_W, 16, width of trig_count
DEADTIME, 4, per-channel retrigger mask length in FCLK cycles (used only with TRIG_DEADTIME_EN)

Ports:
FCLK  input  1  sampling clock; all logic on posedge
INST_START  input  1  reset, synchronous, active-high; also restarts blanking
DISCRIMINATOR_OUTPUT  input  NUM_CH  raw async discriminator outputs
DISCRIMINATOR_POLARITY  input  NUM_CH  per-channel: 1 = inverted active level
CH_ENABLE  input  NUM_CH  per-channel enable
TRIG_MODE  input  2  00 OR, 01 AND, 10 MAJORITY, 11 INDEPENDENT
MAJ_THRESH  input  $clog2(NUM_CH+1)  majority threshold
HOLDOFF_CYCLES  input  HOLDOFF_W  blanking length after INST_START
current_state  input  state_t  global FSM state
trigger  output  NUM_CH  registered per-channel trigger
trigger_any  output  1  registered OR of trigger
armed  output  1  1 when blanking has completed
trig_count  output  CNT_W  accepted trigger_any rising edges, saturating

Behaviour:
- Reset: INST_START sampled high at posedge FCLK clears the following to 0 on that edge:
  - trigger, trigger_any, armed, trig_count
  - synchroniser flops, blank counter, deadtime counters
  - arm FSM goes to BLANK.
- Arm FSM, states BLANK and ARMED:
  - BLANK: blank_cnt increments each cycle. When blank_cnt == HOLDOFF_CYCLES, next state is ARMED and armed=1.
  - HOLDOFF_CYCLES=0 gives armed=1 one cycle after INST_START deasserts.
  - HOLDOFF_CYCLES is sampled continuously in BLANK.
  - ARMED persists until INST_START. INST_START in ARMED returns to BLANK and clears outputs on the same edge.
- Input path:
  - Each DISCRIMINATOR_OUTPUT bit passes through SYNC_STAGES flops.
  - hit[i] = (sync[i] ^ DISCRIMINATOR_POLARITY[i]) & CH_ENABLE[i].
- Gate: gate = 1 unless current_state is STATE_STOPPED, STATE_INIT or STATE_READOUT.
- Combine rule. popcnt = number of set hit bits, computed at width $clog2(NUM_CH+1).
  - OR: fire = hit when |hit, else 0.
  - AND: fire = hit when hit == CH_ENABLE and CH_ENABLE != 0, else 0.
  - MAJORITY: fire = hit when popcnt >= MAJ_THRESH and MAJ_THRESH != 0, else 0. MAJ_THRESH=0 never fires.
  - INDEPENDENT: fire = hit.
- Output register: trigger <= fire & {NUM_CH{gate & armed}}, and trigger_any <= |(next trigger).
  - Both are in the same cycle: trigger_any = |trigger.
  - Latency from a DISCRIMINATOR_OUTPUT edge to trigger = SYNC_STAGES+1 FCLK cycles.
  - Level-following: trigger stays high while the condition holds.
- Gate drop mid-trigger: trigger clears on the next edge. The arm FSM and trig_count are unaffected.
- trig_count: increments on each 0->1 transition of trigger_any. It holds at 2^CNT_W-1 and does not wrap.
- Mode or polarity change while ARMED takes effect on the next register update. There is no glitch filtering beyond the registers.

Optional Feature:
TRIG_DEADTIME_EN
- Defined: a per-channel counter loads DEADTIME on each 0->1 of trigger[i].
  - While the counter is nonzero, fire[i] is forced 0 and the counter decrements each cycle.
  - Net effect: trigger[i] can assert at most once per DEADTIME+1 cycles after its last rising edge.
  - Counters clear on INST_START. DEADTIME=0 disables masking.
- Undefined: no deadtime logic; behaviour is purely level-following as above.

Test Plan:
1. Blanking: HOLDOFF_CYCLES=10, INST_START pulse, OR mode, ch0 held active. Required: armed=0 and trigger=0 for 10 cycles after release, then armed=1, trigger[0]=1 on the following edge.
2. Polarity and latency: SYNC_STAGES=2, POLARITY=8'h01, ch0 input driven low at cycle t. Required: trigger[0] rises at t+3; ch1 high with POLARITY bit 0 gives trigger[1]=1.
3. Majority: NUM_CH=8, MAJ_THRESH=3, CH_ENABLE=8'hFF.
   - hits 8'h03: trigger=0.
   - hits 8'h07: trigger=8'h07, trigger_any=1.
   - MAJ_THRESH=0 with hits 8'hFF: trigger=0.
4. AND and gating: CH_ENABLE=8'h0F, all inputs active.
   - AND mode: trigger=8'h0F.
   - current_state=STATE_READOUT: trigger=0 next cycle, armed stays 1.
   - CH_ENABLE=0: trigger=0.
5. Counter saturation: CNT_W=4, 20 separate trigger_any pulses. Required: trig_count=15; INST_START returns it to 0.
6. Deadtime (TRIG_DEADTIME_EN, DEADTIME=4): ch2 input pulsed every cycle. Required: trigger[2] asserts once per 5 cycles. Without the macro: trigger[2] follows the input with 3-cycle latency.
